// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
// Iterative radix-2 restoring divider (unsigned). One quotient bit per
// unstalled RUN cycle, WIDTH iterations per operation. With EARLY_EXIT=1 the
// divide-by-zero and dividend<divisor cases finish straight from IDLE. The
// result bits are the same in both modes; only the timing differs.
// The D inputs of the quotient/remainder registers are exported so that
// shadow or predicate logic outside the block can follow the datapath.
module seq_restoring_divider #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       state_o,
    output logic [WIDTH-1:0] quo_next,
    output logic [WIDTH-1:0] rem_next
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Result of one restoring iteration.
    typedef struct packed {
        logic [WIDTH:0]   rem;
        logic [WIDTH-1:0] quo;
    } step_t;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor if it fits, and shift the decision bit
    // into the quotient. The top remainder bit takes part in the compare so the
    // step stays exact for any register content; in normal operation it is 0.
    // The subtract is WIDTH+1 bits wide so divisors above 2^(WIDTH-1) cannot
    // overflow.
    function automatic step_t div_step(input logic [WIDTH:0]   rem,
                                       input logic [WIDTH-1:0] quo,
                                       input logic [WIDTH-1:0] dvs);
        logic [WIDTH+1:0] shifted;
        logic [WIDTH+1:0] dvs_ext;
        logic [WIDTH:0]   diff;
        step_t            res;
        shifted = {rem, quo[WIDTH-1]};
        dvs_ext = {2'b00, dvs};
        diff    = shifted[WIDTH:0] - {1'b0, dvs};
        if (shifted >= dvs_ext) begin
            res.rem = diff;
            res.quo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            res.rem = shifted[WIDTH:0];
            res.quo = {quo[WIDTH-2:0], 1'b0};
        end
        return res;
    endfunction

    state_e           state_q,   state_d,   state_adv;
    logic [WIDTH-1:0] quo_q,     quo_d,     quo_adv;
    logic [WIDTH:0]   rem_q,     rem_d,     rem_adv;
    logic [WIDTH-1:0] dvs_q,     dvs_d,     dvs_adv;
    logic [CW-1:0]    cnt_q,     cnt_d,     cnt_adv;
    logic             dbz_q,     dbz_d,     dbz_adv;
    step_t            step_s;

    // Unstalled next state: accept/shortcut in IDLE, iterate in RUN, leave DONE.
    always_comb begin
        state_adv = state_q;
        quo_adv   = quo_q;
        rem_adv   = rem_q;
        dvs_adv   = dvs_q;
        cnt_adv   = cnt_q;
        dbz_adv   = dbz_q;
        step_s    = div_step(rem_q, quo_q, dvs_q);
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    quo_adv = dividend;
                    rem_adv = {(WIDTH + 1){1'b0}};
                    dvs_adv = divisor;
                    cnt_adv = {CW{1'b0}};
                    dbz_adv = (divisor == {WIDTH{1'b0}});
                    if (EARLY_EXIT && (divisor == {WIDTH{1'b0}})) begin
                        // Same bits the full loop would produce for x/0.
                        quo_adv   = {WIDTH{1'b1}};
                        rem_adv   = {1'b0, dividend};
                        state_adv = ST_DONE;
                    end else if (EARLY_EXIT && (dividend < divisor)) begin
                        quo_adv   = {WIDTH{1'b0}};
                        rem_adv   = {1'b0, dividend};
                        state_adv = ST_DONE;
                    end else begin
                        state_adv = ST_RUN;
                    end
                end else begin
                    state_adv = ST_IDLE;
                end
            end
            ST_RUN: begin
                quo_adv = step_s.quo;
                rem_adv = step_s.rem;
                cnt_adv = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_adv = ST_DONE;
                end else begin
                    state_adv = ST_RUN;
                end
            end
            ST_DONE: begin
                state_adv = ST_IDLE;
            end
            default: begin
                state_adv = ST_IDLE;
            end
        endcase
    end

    // Stall freezes every register, in every state (also blocks accept).
    always_comb begin
        if (stall) begin
            state_d = state_q;
            quo_d   = quo_q;
            rem_d   = rem_q;
            dvs_d   = dvs_q;
            cnt_d   = cnt_q;
            dbz_d   = dbz_q;
        end else begin
            state_d = state_adv;
            quo_d   = quo_adv;
            rem_d   = rem_adv;
            dvs_d   = dvs_adv;
            cnt_d   = cnt_adv;
            dbz_d   = dbz_adv;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {(WIDTH + 1){1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE) && !stall;
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;
    assign state_o     = state_q;
    assign quo_next    = quo_d;
    assign rem_next    = rem_d[WIDTH-1:0];

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: two copies (index 0: EARLY_EXIT=0,
// index 1: EARLY_EXIT=1) with separate stimulus. Expected results come from
// a reference model (/ and %) pushed to a scoreboard queue on accept and
// popped when out_valid appears.
module tb_seq_restoring_divider;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n       [2];
    logic         in_valid    [2];
    logic         stall       [2];
    logic [W-1:0] dividend    [2];
    logic [W-1:0] divisor     [2];
    logic         in_ready    [2];
    logic         busy        [2];
    logic         out_valid   [2];
    logic [W-1:0] quotient    [2];
    logic [W-1:0] remainder   [2];
    logic         div_by_zero [2];
    logic [1:0]   state_o     [2];
    logic [W-1:0] quo_next    [2];
    logic [W-1:0] rem_next    [2];

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam int NDIR = 6;
    localparam logic [W-1:0] BASIC_A [NDIR] = '{16'd100, 16'hFFFF, 16'h8000, 16'hFFFF, 16'd1000, 16'hABCD};
    localparam logic [W-1:0] BASIC_B [NDIR] = '{16'd7,   16'h8001, 16'h8000, 16'hFFFF, 16'd1,    16'h0013};
    localparam int NEE = 5;
    localparam logic [W-1:0] EE_A [NEE] = '{16'd5, 16'h1234, 16'd0, 16'd0, 16'hFFFE};
    localparam logic [W-1:0] EE_B [NEE] = '{16'd9, 16'd0,    16'd5, 16'd0, 16'hFFFF};

    seq_restoring_divider #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_const (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .stall(stall[0]),
        .dividend(dividend[0]), .divisor(divisor[0]), .in_ready(in_ready[0]),
        .busy(busy[0]), .out_valid(out_valid[0]), .quotient(quotient[0]),
        .remainder(remainder[0]), .div_by_zero(div_by_zero[0]), .state_o(state_o[0]),
        .quo_next(quo_next[0]), .rem_next(rem_next[0])
    );

    seq_restoring_divider #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_early (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .stall(stall[1]),
        .dividend(dividend[1]), .divisor(divisor[1]), .in_ready(in_ready[1]),
        .busy(busy[1]), .out_valid(out_valid[1]), .quotient(quotient[1]),
        .remainder(remainder[1]), .div_by_zero(div_by_zero[1]), .state_o(state_o[1]),
        .quo_next(quo_next[1]), .rem_next(rem_next[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one accept cycle and push the model result; returns 1 cycle after accept edge.
    task automatic issue(input int d, input logic [W-1:0] a, input logic [W-1:0] b, input int extra);
        exp_t e;
        e.dbz = (b == 16'd0);
        e.q   = (b == 16'd0) ? 16'hFFFF : a / b;
        e.r   = (b == 16'd0) ? a : a % b;
        e.lat = ((d == 1) && ((b == 16'd0) || (a < b))) ? 1 : W + 1;
        e.lat = e.lat + extra;
        sb.push_back(e);
        dividend[d] = a;
        divisor[d]  = b;
        in_valid[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts edges from the accept edge inclusive.
    task automatic wait_out(input int d, input int lat_in, output int lat_out, output bit to);
        int lat;
        lat = lat_in;
        while ((out_valid[d] !== 1'b1) && (lat < 200)) begin
            tick();
            lat++;
        end
        to      = (out_valid[d] !== 1'b1);
        lat_out = lat;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; in_valid[d] = 1'b0; stall[d] = 1'b0;
            dividend[d] = 16'd0; divisor[d] = 16'd0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (state_o[d] !== 2'd0 || busy[d] !== 1'b0 || out_valid[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state d=%0d: state=%0d busy=%b out_valid=%b, want 0/0/0", d, state_o[d], busy[d], out_valid[d]);
            end
            total++;
            if (quotient[d] !== 16'd0 || remainder[d] !== 16'd0 || div_by_zero[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_data d=%0d: q=%h r=%h dbz=%b, want 0/0/0", d, quotient[d], remainder[d], div_by_zero[d]);
            end
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) rst_n[d] = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (in_ready[d] !== 1'b1 || quo_next[d] !== quotient[d] || rem_next[d] !== remainder[d]) begin
                bad++;
                $display("FAIL idle_taps d=%0d: in_ready=%b quo_next=%h rem_next=%h, want 1/%h/%h", d, in_ready[d], quo_next[d], rem_next[d], quotient[d], remainder[d]);
            end
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] a, b;
        exp_t e;
        int   lat;
        bit   to;
        for (int i = 0; i < NDIR + 8; i++) begin
            if (i < NDIR) begin
                a = BASIC_A[i];
                b = BASIC_B[i];
            end else begin
                a = W'($urandom_range(0, 65535));
                b = (i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom_range(0, 65535));
            end
            for (int d = 0; d < 2; d++) begin
                issue(d, a, b, 0);
                wait_out(d, 1, lat, to);
                e = sb.pop_front();
                total++;
                if (to || lat != e.lat) begin
                    bad++;
                    $display("FAIL basic_latency d=%0d %h/%h: got %0d want %0d", d, a, b, lat, e.lat);
                end
                total++;
                if (quotient[d] !== e.q || remainder[d] !== e.r || div_by_zero[d] !== e.dbz) begin
                    bad++;
                    $display("FAIL basic_result d=%0d %h/%h: q=%h r=%h dbz=%b want %h %h %b", d, a, b, quotient[d], remainder[d], div_by_zero[d], e.q, e.r, e.dbz);
                end
                tick();
                total++;
                if (out_valid[d] !== 1'b0 || state_o[d] !== 2'd0 || quotient[d] !== e.q) begin
                    bad++;
                    $display("FAIL basic_done_len d=%0d: out_valid=%b state=%0d q=%h want 0 0 %h", d, out_valid[d], state_o[d], quotient[d], e.q);
                end
            end
        end
    endtask

    task automatic test_early_exit();
        exp_t e;
        int   lat;
        bit   to;
        for (int i = 0; i < NEE; i++) begin
            for (int d = 0; d < 2; d++) begin
                issue(d, EE_A[i], EE_B[i], 0);
                wait_out(d, 1, lat, to);
                e = sb.pop_front();
                total++;
                if (to || lat != e.lat) begin
                    bad++;
                    $display("FAIL ee_latency d=%0d %h/%h: got %0d want %0d", d, EE_A[i], EE_B[i], lat, e.lat);
                end
                total++;
                if (quotient[d] !== e.q || remainder[d] !== e.r || div_by_zero[d] !== e.dbz) begin
                    bad++;
                    $display("FAIL ee_result d=%0d %h/%h: q=%h r=%h dbz=%b want %h %h %b", d, EE_A[i], EE_B[i], quotient[d], remainder[d], div_by_zero[d], e.q, e.r, e.dbz);
                end
                tick();
                total++;
                if (out_valid[d] !== 1'b0 || state_o[d] !== 2'd0) begin
                    bad++;
                    $display("FAIL ee_done_len d=%0d: out_valid=%b state=%0d want 0 0", d, out_valid[d], state_o[d]);
                end
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   lat;
        bit   to;
        // Stall in IDLE blocks the accept.
        stall[1] = 1'b1; in_valid[1] = 1'b1; dividend[1] = 16'd9; divisor[1] = 16'd3;
        #1;
        total++;
        if (in_ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL stall_idle_ready: in_ready=%b want 0", in_ready[1]);
        end
        tick();
        total++;
        if (state_o[1] !== 2'd0) begin
            bad++;
            $display("FAIL stall_idle_accept: state=%0d want 0", state_o[1]);
        end
        in_valid[1] = 1'b0; stall[1] = 1'b0;
        // 0xFFFF/1, stalled 3 cycles at RUN cnt=4.
        issue(1, 16'hFFFF, 16'h0001, 3);
        lat = 1;
        while (lat < 5) begin
            tick();
            lat++;
        end
        stall[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            lat++;
            total++;
            if (out_valid[1] !== 1'b0 || busy[1] !== 1'b1 || quo_next[1] !== quotient[1] || rem_next[1] !== remainder[1]) begin
                bad++;
                $display("FAIL stall_run_hold k=%0d: out_valid=%b busy=%b quo_next=%h q=%h rem_next=%h r=%h", k, out_valid[1], busy[1], quo_next[1], quotient[1], rem_next[1], remainder[1]);
            end
        end
        stall[1] = 1'b0;
        wait_out(1, lat, lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != e.lat || lat != 20) begin
            bad++;
            $display("FAIL stall_latency: got %0d want 20", lat);
        end
        total++;
        if (quotient[1] !== 16'hFFFF || remainder[1] !== 16'h0000 || div_by_zero[1] !== 1'b0) begin
            bad++;
            $display("FAIL stall_result: q=%h r=%h dbz=%b want ffff 0000 0", quotient[1], remainder[1], div_by_zero[1]);
        end
        // Stall in DONE keeps out_valid high.
        stall[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (out_valid[1] !== 1'b1 || quotient[1] !== 16'hFFFF) begin
                bad++;
                $display("FAIL stall_done_hold k=%0d: out_valid=%b q=%h want 1 ffff", k, out_valid[1], quotient[1]);
            end
        end
        stall[1] = 1'b0;
        tick();
        total++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            bad++;
            $display("FAIL stall_done_release: out_valid=%b in_ready=%b want 0 1", out_valid[1], in_ready[1]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   to;
        issue(1, 16'd100, 16'd7, 0);
        lat = 1;
        while (lat < 5) begin
            tick();
            lat++;
        end
        // Held request during RUN/DONE must be ignored.
        in_valid[1] = 1'b1; dividend[1] = 16'd50; divisor[1] = 16'd3;
        wait_out(1, lat, lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != 17) begin
            bad++;
            $display("FAIL b2b_first_latency: got %0d want 17", lat);
        end
        total++;
        if (quotient[1] !== 16'd14 || remainder[1] !== 16'd2 || in_ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first_result: q=%0d r=%0d in_ready=%b want 14 2 0", quotient[1], remainder[1], in_ready[1]);
        end
        tick();
        total++;
        if (state_o[1] !== 2'd0 || in_ready[1] !== 1'b1 || quotient[1] !== 16'd14 || remainder[1] !== 16'd2) begin
            bad++;
            $display("FAIL b2b_idle_hold: state=%0d in_ready=%b q=%0d r=%0d want 0 1 14 2", state_o[1], in_ready[1], quotient[1], remainder[1]);
        end
        e.q = 16'd16; e.r = 16'd2; e.dbz = 1'b0; e.lat = 17;
        sb.push_back(e);
        tick();
        in_valid[1] = 1'b0;
        total++;
        if (busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_accept: busy=%b want 1", busy[1]);
        end
        wait_out(1, 1, lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != e.lat || quotient[1] !== e.q || remainder[1] !== e.r) begin
            bad++;
            $display("FAIL b2b_second_result: lat=%0d q=%0d r=%0d want %0d %0d %0d", lat, quotient[1], remainder[1], e.lat, e.q, e.r);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   lat;
        int   seen;
        bit   to;
        issue(0, 16'd100, 16'd7, 0);
        lat = 1;
        while (lat < 5) begin
            tick();
            lat++;
        end
        rst_n[0] = 1'b0;
        e = sb.pop_front();
        #1;
        total++;
        if (state_o[0] !== 2'd0 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || quotient[0] !== 16'd0 || remainder[0] !== 16'd0 || div_by_zero[0] !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: state=%0d busy=%b ov=%b q=%h r=%h dbz=%b want all 0", state_o[0], busy[0], out_valid[0], quotient[0], remainder[0], div_by_zero[0]);
        end
        tick();
        tick();
        rst_n[0] = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid[0] === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrun_no_out_valid: out_valid seen %0d cycles want 0", seen);
        end
        issue(0, 16'd9, 16'd3, 0);
        wait_out(0, 1, lat, to);
        e = sb.pop_front();
        total++;
        if (to || lat != e.lat || quotient[0] !== 16'd3 || remainder[0] !== 16'd0) begin
            bad++;
            $display("FAIL midrun_followup: lat=%0d q=%0d r=%0d want %0d 3 0", lat, quotient[0], remainder[0], e.lat);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_exit();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
